shift_tx: RTL and testbench

SHIFT_TX -- requirements
Module: shift_tx

---
 rtl/shift_tx.sv | 77 +++++++
 tb/tb_shift_tx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/shift_tx.sv
// shift_tx: LSB-first parallel-to-serial transmitter; define SHIFT_TX_PARITY_EN to append an XOR parity bit
module shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic r_par;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_armed;
  logic             w_accept, w_last;
  assign w_accept = load_valid & load_ready;
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  // shift register, bit counter and the ready gate that opens one edge after reset release
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_shreg <= load_data;
        r_cnt   <= '0;
`ifdef SHIFT_TX_PARITY_EN
        r_par   <= ^load_data;
`endif
      end else if (r_state == SHIFT) begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
        r_cnt   <= w_last ? r_cnt : r_cnt + 1'b1;
      end
    end
  // next-state logic
  always_comb begin
`ifdef SHIFT_TX_PARITY_EN
    w_next = (r_state == IDLE)  ? (w_accept ? SHIFT : IDLE) :
             (r_state == SHIFT) ? (w_last ? PARITY : SHIFT) : IDLE;
`else
    w_next = (r_state == IDLE) ? (w_accept ? SHIFT : IDLE) : (w_last ? IDLE : SHIFT);
`endif
  end
  // outputs decoded from state
  always_comb begin
    load_ready = (r_state == IDLE) & r_armed;
    busy       = r_state != IDLE;
    sout_valid = r_state != IDLE;
`ifdef SHIFT_TX_PARITY_EN
    sout       = (r_state == SHIFT) ? r_shreg[0] : (r_state == PARITY) ? r_par : 1'b0;
    done       = r_state == PARITY;
`else
    sout       = (r_state == SHIFT) & r_shreg[0];
    done       = (r_state == SHIFT) & w_last;
`endif
  end
endmodule

// File: tb/tb_shift_tx.sv
// tb_shift_tx: scoreboard bench for shift_tx with a right-shift receiver model
module tb_shift_tx;
  localparam int W = 4;
`ifdef SHIFT_TX_PARITY_EN
  localparam int FR = W + 1;
`else
  localparam int FR = W;
`endif
  typedef struct packed {logic b; logic d;} exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready, sout, sout_valid, busy, done;
  exp_t         exp_q[$];
  logic [W-1:0] word_q[$];
  logic [W-1:0] rx = '0;
  int           rx_n = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           n;
  shift_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // push the expected frame for a word being accepted at the coming edge
  task automatic push_frame(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) exp_q.push_back('{b: d[i], d: (FR == W) && (i == W - 1)});
    if (FR != W) exp_q.push_back('{b: ^d, d: 1'b1});
    word_q.push_back(d);
  endtask
  // monitor: compare outputs against the scoreboard and rebuild words LSB-first
  always @(negedge clk) begin
    exp_t       e;
    logic [W-1:0] w;
    if (!rst) begin
      exp_q.delete();
      word_q.delete();
      rx_n = 0;
    end else begin
      if (sout_valid) begin
        check("busy_in_frame", busy, 1);
        if (exp_q.size() == 0) check("unexpected_valid", sout_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("sout", sout, e.b);
          check("done", done, e.d);
          if (rx_n < W) rx = {sout, rx[W-1:1]};
          rx_n++;
          if (e.d) begin
            w = word_q.pop_front();
            check("rx_word", rx, w);
            rx_n = 0;
          end
        end
      end else check("idle_outputs", {sout, busy, done}, 0);
      if (load_valid && load_ready) push_frame(load_data);
    end
  end
  task automatic wait_ready(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!load_ready && cycles < 50);
    if (!load_ready) check("ready_timeout", load_ready, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] d);
    int c;
    load_valid = 1'b1;
    load_data  = d;
    wait_ready(c);
    load_valid = 1'b0;
  endtask
  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 50) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("drain", exp_q.size(), 0);
  endtask
  initial begin
    #12;
    check("reset_outputs", {load_ready, sout, sout_valid, busy, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_before_edge", load_ready, 0);
    @(posedge clk);
    #1 check("ready_after_release", load_ready, 1);
    send(4'b1011);
    drain();
    check("ready_after_frame", load_ready, 1);
    send(4'b0110);
    drain();
    load_valid = 1'b1;
    load_data  = 4'b0001;
    wait_ready(n);
    load_data  = 4'b1111;
    wait_ready(n);
    check("ignored_load_wait", n, FR + 1);
    load_valid = 1'b0;
    drain();
    load_valid = 1'b1;
    load_data  = 4'b1001;
    wait_ready(n);
    load_data  = 4'b0011;
    wait_ready(n);
    check("b2b_gap", n, FR + 1);
    load_valid = 1'b0;
    drain();
    send(4'b1100);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("abort_outputs", {load_ready, sout, sout_valid, busy, done}, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("abort_ready_low", load_ready, 0);
    check("abort_flushed", exp_q.size(), 0);
    @(posedge clk);
    #1 check("abort_ready_back", load_ready, 1);
    send(4'b0101);
    drain();
    for (int k = 0; k < 6; k++) begin
      send(W'($urandom));
      drain();
    end
    repeat (3) @(posedge clk);
    check("words_left", word_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
